mul8_seq: RTL



---
 rtl/mul8_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around the cska8b
// carry-skip adder. Valid/ready handshakes on the operand and result sides.

module cska8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] p;
    logic [7:0] g;
    logic       carry;
    logic       c4;

    // Two 4-bit ripple blocks; a block whose bits all propagate passes its carry-in straight through.
    always_comb begin
        p     = a ^ b;
        g     = a & b;
        sum   = 8'h00;
        carry = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i] = p[i] ^ carry;
            carry  = g[i] | (p[i] & carry);
        end
        c4    = (&p[3:0]) ? cin : carry;
        carry = c4;
        for (int i = 4; i < 8; i++) begin
            sum[i] = p[i] ^ carry;
            carry  = g[i] | (p[i] & carry);
        end
        cout = (&p[7:4]) ? c4 : carry;
    end
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one shift-and-add iteration per cycle, 8 cycles
// DONE  | product valid, waiting for out_ready
module mul8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  m;
    logic [7:0]  p_hi;
    logic [7:0]  q;
    logic [2:0]  cnt;
    logic [7:0]  add_b;
    logic [7:0]  s;
    logic        c;

    assign add_b = q[0] ? m : 8'h00;

    cska8b u_add (
        .a    (p_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (s),
        .cout (c)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m       <= 8'h00;
            p_hi    <= 8'h00;
            q       <= 8'h00;
            cnt     <= 3'd0;
            product <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m     <= a;
                        q     <= b;
                        p_hi  <= 8'h00;
                        cnt   <= 3'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The adder carry-out lands in p_hi[7] as the pair shifts right.
                    p_hi <= {c, s[7:1]};
                    q    <= {s[0], q[7:1]};
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        product <= {c, s, q[7:1]};
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
